// File: rtl/bm_dl_pipelined_nbit_addsub_with_flags_if.sv
// ----------------------------------------------------------------------------
// bm_dl_pipelined_nbit_addsub_with_flags_if
// Purpose : groups the operand/result streams and the overflow counter signals
//           of the pipelined add/subtract block into one bundle.
// Signals : in_valid/in_ready         - operand beat handshake
//           sub, carryin, X, Y        - operation select, carry/borrow, operands
//           out_valid/out_ready       - result beat handshake
//           S, carryout, overflow     - result and flags
//           ovf_clear, ovf_count      - overflow event counter clear / value
// Modports: slave  - the arithmetic block
//           master - the producer/consumer driving it
// ----------------------------------------------------------------------------
interface bm_dl_pipelined_nbit_addsub_with_flags_if #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic               sub;
    logic               carryin;
    logic [WIDTH-1:0]   X;
    logic [WIDTH-1:0]   Y;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   S;
    logic               carryout;
    logic               overflow;
    logic               ovf_clear;
    logic [COUNT_W-1:0] ovf_count;

    modport slave (
        input  in_valid, sub, carryin, X, Y, out_ready, ovf_clear,
        output in_ready, out_valid, S, carryout, overflow, ovf_count
    );

    modport master (
        output in_valid, sub, carryin, X, Y, out_ready, ovf_clear,
        input  in_ready, out_valid, S, carryout, overflow, ovf_count
    );
endinterface

// File: rtl/bm_dl_pipelined_nbit_addsub_with_flags.sv
// ----------------------------------------------------------------------------
// bm_dl_pipelined_nbit_addsub_with_flags
// Purpose : streaming WIDTH-bit add/subtract with carry-out and exact signed
//           overflow. The carry chain is cut into STAGES segments of CW bits,
//           one segment added per register stage, behind an operand capture
//           register, so a result appears STAGES edges after its acceptance.
//           A saturating counter records delivered results that overflowed.
// Ports   : clock   - rising-edge clock
//           reset_n - asynchronous active-low reset
//           bus     - slave side of bm_dl_pipelined_nbit_addsub_with_flags_if
// ----------------------------------------------------------------------------
module bm_dl_pipelined_nbit_addsub_with_flags #(
    parameter int WIDTH   = 32,
    parameter int STAGES  = 4,
    parameter int COUNT_W = 8
) (
    input  logic clock,
    input  logic reset_n,
    bm_dl_pipelined_nbit_addsub_with_flags_if.slave bus
);
    localparam int CW    = WIDTH / STAGES;
    // Slot 0 captures operands; slot k (1..STAGES) holds the sum up to segment k-1.
    localparam int DEPTH = STAGES + 1;

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1'b1);

    // Pipeline slots. r_x / r_y carry the not-yet-added upper segments (skew),
    // r_s accumulates the already-computed lower sum segments (deskew).
    logic             r_v [DEPTH];
    logic [WIDTH-1:0] r_x [DEPTH];
    logic [WIDTH-1:0] r_y [DEPTH];
    logic [WIDTH-1:0] r_s [DEPTH];
    logic             r_c [DEPTH];
    logic             r_ovf;
    logic [COUNT_W-1:0] r_cnt;

    logic             w_adv;
    logic [WIDTH-1:0] w_s_nx [DEPTH];
    logic             w_c_nx [DEPTH];
    logic [CW:0]      w_sum_seg;
    logic             w_ovf_nx;
    logic             w_xfer;

    // One CW-bit segment of the carry chain, carry-out in the top bit.
    function automatic logic [CW:0] seg_add(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic          cin);
        seg_add = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    endfunction

    // The whole pipeline moves unless a finished result is being held back.
    assign w_adv  = ~(r_v[STAGES] & ~bus.out_ready);
    assign w_xfer = r_v[STAGES] & bus.out_ready;

    // Per-stage segment addition feeding the next slot.
    always_comb begin
        w_sum_seg = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_s_nx[k] = '0;
            w_c_nx[k] = 1'b0;
        end
        for (int k = 1; k < DEPTH; k++) begin
            w_sum_seg = seg_add(r_x[k-1][(k-1)*CW +: CW],
                                r_y[k-1][(k-1)*CW +: CW],
                                r_c[k-1]);
            w_s_nx[k] = r_s[k-1];
            w_s_nx[k][(k-1)*CW +: CW] = w_sum_seg[CW-1:0];
            w_c_nx[k] = w_sum_seg[CW];
        end
        // Carry into the MSB is recovered as x^y^s at that bit, so the flag is
        // exact signed overflow rather than a guess from operand signs.
        w_ovf_nx = w_c_nx[STAGES] ^ r_x[STAGES-1][WIDTH-1]
                 ^ r_y[STAGES-1][WIDTH-1] ^ w_s_nx[STAGES][WIDTH-1];
    end

    // Pipeline registers: capture slot plus one slot per carry segment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_v[k] <= 1'b0;
                r_x[k] <= '0;
                r_y[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            // Subtraction folds into addition: X + ~Y + ~borrow.
            r_v[0] <= bus.in_valid & w_adv;
            r_x[0] <= bus.X;
            r_y[0] <= bus.sub ? ~bus.Y : bus.Y;
            r_c[0] <= bus.carryin ^ bus.sub;
            r_s[0] <= '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k] <= r_v[k-1];
                r_x[k] <= r_x[k-1];
                r_y[k] <= r_y[k-1];
                r_s[k] <= w_s_nx[k];
                r_c[k] <= w_c_nx[k];
            end
            r_ovf <= w_ovf_nx;
        end
    end

    // Saturating count of delivered overflowing results; clear wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (bus.ovf_clear) begin
            r_cnt <= '0;
        end else if (w_xfer && r_ovf && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_v[STAGES];
    assign bus.S         = r_s[STAGES];
    assign bus.carryout  = r_c[STAGES];
    assign bus.overflow  = r_ovf;
    assign bus.ovf_count = r_cnt;
endmodule

// File: doc/bm_dl_pipelined_nbit_addsub_with_flags.md
# bm_DL_pipelined_nbit_addsub_with_flags

Parametrised, pipelined successor to the single-cycle n-bit adder with carry-out and overflow. It adds or subtracts two WIDTH-bit operands with a carry/borrow input. The carry chain is split across STAGES register stages, and it produces carry-out and signed overflow flags. A valid/ready handshake on both sides gives it backpressure, and a saturating counter records overflow events. It sits in the arithmetic regression set as the sequential, streaming counterpart of the combinational adder benchmarks.

## Interface
- WIDTH, 32, operand/result width; must be divisible by STAGES.
- STAGES, 4, pipeline depth and carry-chain segment count; 1 ≤ STAGES ≤ WIDTH. Segment width CW = WIDTH/STAGES.
- COUNT_W, 8, width of the overflow event counter.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- sub  in  1  0 = add, 1 = subtract.
- carryin  in  1  carry-in (add) / borrow-in (subtract).
- X, Y  in  WIDTH  operands, two's complement for overflow purposes.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- S  out  WIDTH  result.
- carryout  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow of this result.
- ovf_clear  in  1  synchronous clear of ovf_count.
- ovf_count  out  COUNT_W  saturating count of delivered results with overflow=1.

## Operation
- **Add (sub=0):** {carryout,S} = X + Y + carryin.
- **Subtract (sub=1):** {carryout,S} = X + ~Y + ~carryin, i.e. S = X − Y − carryin mod 2^WIDTH.
  - carryout=1 means no borrow.
- **Overflow:** overflow = (carry into bit WIDTH-1) XOR carryout. The flag must be exact signed overflow, not an XOR of operand MSBs.
- **Stage k (0..STAGES-1):**
  - Adds segment k bits [k·CW+CW-1 : k·CW] of X and the effective Y, using the carry registered by stage k-1 (the effective carry-in for k=0).
  - Registers the partial sum and the segment carry.
  - Skew registers hold the upper, not-yet-added operand segments.
  - Deskew registers hold the lower, already-computed sum segments.
- **Per-stage valid bit:**
  - Global advance enable: adv = ~(out_valid & ~out_ready).
  - When adv=1, every stage loads from its predecessor. Stage 0 loads in_valid & in_ready.
  - When adv=0, all pipeline registers hold.
  - Bubbles are not collapsed.
- **Handshake:** in_ready = adv (combinational from out_valid and out_ready only, never from in_valid).
- **Output transfer:** out_valid & out_ready at a rising edge. On transfer with overflow=1, ovf_count increments and saturates at 2^COUNT_W−1.
- **ovf_clear=1:** ovf_count ← 0 next edge. Clear takes priority over a simultaneous increment.
- **Reset (reset_n=0, any time including mid-stream):**
  - Immediately forces all valid bits, out_valid, S, carryout, overflow, ovf_count and all internal carries to 0.
  - In-flight beats are discarded.
  - in_ready reads 1 while in reset.

## Timing
- **Input acceptance:** a beat is accepted on the rising edge where in_valid & in_ready.
- **Latency:** with no stall, the result is presented with out_valid=1 exactly STAGES edges after acceptance. STAGES=1 gives one-cycle registered behaviour.
- **Throughput:** one beat per cycle while out_ready=1.
- **Output hold:** outputs S, carryout, overflow are registered and remain stable while out_valid & ~out_ready. No beat is lost, duplicated or reordered.
- **Stall release:** when out_ready rises, the held beat transfers on that edge and the pipeline advances on the same edge.
- **Counter update:** ovf_count updates on the edge following the transfer/clear condition.
- **Reset values:** out_valid 0, S 0, carryout 0, overflow 0, ovf_count 0.

## Test plan
All scenarios use WIDTH=32, STAGES=4, COUNT_W=8.

- **Reset:** reset_n=0 for 3 cycles, then release -> out_valid=0, S=0, carryout=0, overflow=0, ovf_count=0, in_ready=1.
- **Carry ripple across all segments:** X=0xFFFFFFFF, Y=1, sub=0, carryin=0, accepted at edge t -> at edge t+4: out_valid=1, S=0x00000000, carryout=1, overflow=0.
- **Add overflow:** X=0x7FFFFFFF, Y=0, carryin=1 -> S=0x80000000, carryout=0, overflow=1; ovf_count=1 after transfer.
- **Subtract:**
  - X=5, Y=7, sub=1, carryin=0 -> S=0xFFFFFFFE, carryout=0, overflow=0.
  - X=0x80000000, Y=1, sub=1, carryin=0 -> S=0x7FFFFFFF, carryout=1, overflow=1.
- **Backpressure:** stream 8 random beats back-to-back; hold out_ready=0 for 3 cycles starting at the first valid output -> in_ready=0 during the stall, outputs held stable, all 8 results match the reference model in order, no duplicates.
- **Counter saturation and reset mid-stream:**
  - Drive 300 overflowing results -> ovf_count saturates at 255.
  - ovf_clear asserted on the same edge as an overflowing transfer -> ovf_count=0.
  - Assert reset_n=0 with 3 beats in flight -> out_valid=0 immediately; no stale beat emerges after release.
